// File: rtl/imm_builder_pkg.sv
// imm_builder_pkg: shared op encodings, FSM state type and default widths
// for the immediate-load unit.
package imm_builder_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned IMM_W_DEF      = 8;
  localparam int unsigned REG_ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_LUI   = 2'd0,
    OP_LLI   = 2'd1,
    OP_CHAIN = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/imm_builder_if.sv
// imm_builder_if: request side (decode -> unit) and RegFile write side
// (unit -> RegFile) of the immediate-load unit.
//   master: drives the request, observes ready and the write port (decode/bench)
//   slave : the imm_builder itself
interface imm_builder_if
  import imm_builder_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned IMM_W      = IMM_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  op_e                   op;
  logic [IMM_W-1:0]      imm;
  logic [REG_ADDR_W-1:0] dest;
  logic                  last;
  logic [DATA_W-1:0]     old_data;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0]     WriteData;
  logic                  busy;
  logic                  err;

  modport master (
    output in_valid, op, imm, dest, last, old_data,
    input  in_ready, RegWrite, WriteReg, WriteData, busy, err
  );

  modport slave (
    input  in_valid, op, imm, dest, last, old_data,
    output in_ready, RegWrite, WriteReg, WriteData, busy, err
  );

endinterface

// File: rtl/imm_merge.sv
// imm_merge: combinational placement of one immediate fragment.
//   op_i       : LUI -> upper field, LLI -> lower field, CHAIN -> shift into base
//   base_i     : running accumulator (zero when a chain starts)
//   old_data_i : current register contents, upper part kept by LLI
//   imm_i      : fragment
//   merged_o   : composed DATA_W-bit value
module imm_merge
  import imm_builder_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] old_data_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] merged_o
);

  localparam int unsigned UPPER_SH = DATA_W - IMM_W;

  // Low field of old_data is always replaced by the fragment.
  logic [IMM_W-1:0] unused_old_low;
  assign unused_old_low = old_data_i[IMM_W-1:0];

  always_comb begin
    merged_o = base_i;
    case (op_i)
      OP_LUI:   merged_o = DATA_W'(imm_i) << UPPER_SH;
      OP_LLI:   merged_o = {old_data_i[DATA_W-1:IMM_W], imm_i};
      // Oldest bits fall off the top, keeping the newest DATA_W/IMM_W fragments.
      OP_CHAIN: merged_o = (base_i << IMM_W) | DATA_W'(imm_i);
      default:  merged_o = base_i;
    endcase
  end

endmodule

// File: rtl/imm_builder.sv
// imm_builder: composes a DATA_W-bit constant from immediate fragments and
// writes it to the RegFile with a one-cycle RegWrite pulse.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : imm_builder_if.slave (request in, RegFile write port out)
// Build option: IMM_BUILDER_CHAIN_EN enables CHAIN and the ACCUM state;
// without it op 2 is rejected like the reserved op.
module imm_builder
  import imm_builder_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned IMM_W      = IMM_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  imm_builder_if.slave bus
);

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  err_q, err_d;

  logic                  accept_c;
  logic [DATA_W-1:0]     merge_base_c;
  logic [DATA_W-1:0]     merged_c;

  assign accept_c = bus.in_valid && (state_q != ST_WRITE);

`ifdef IMM_BUILDER_CHAIN_EN
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;

  // A CHAIN from IDLE starts from zero; only ACCUM continues the accumulator.
  assign merge_base_c = (state_q == ST_ACCUM) ? acc_q : '0;
`else
  logic unused_last;
  assign unused_last  = bus.last;
  assign merge_base_c = '0;
`endif

  imm_merge #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_merge (
    .op_i       (bus.op),
    .base_i     (merge_base_c),
    .old_data_i (bus.old_data),
    .imm_i      (bus.imm),
    .merged_o   (merged_c)
  );

  // Next-state and write-port decode.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
`ifdef IMM_BUILDER_CHAIN_EN
    acc_d     = acc_q;
    dest_d    = dest_q;
`endif
    if (state_q == ST_WRITE) begin
      state_d = ST_IDLE;
    end else if (accept_c) begin
      // Any non-CHAIN op arriving mid-chain aborts it; the op still executes.
      if ((state_q == ST_ACCUM) && (bus.op != OP_CHAIN)) err_d = 1'b1;
      state_d = ST_IDLE;
      case (bus.op)
        OP_LUI, OP_LLI: begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = bus.dest;
          wr_data_d = merged_c;
        end
        OP_CHAIN: begin
`ifdef IMM_BUILDER_CHAIN_EN
          acc_d = merged_c;
          if (state_q == ST_IDLE) dest_d = bus.dest;
          if (bus.last) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = (state_q == ST_IDLE) ? bus.dest : dest_q;
            wr_data_d = merged_c;
          end else begin
            state_d = ST_ACCUM;
          end
`else
          err_d = 1'b1;
`endif
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
`ifdef IMM_BUILDER_CHAIN_EN
      acc_q     <= '0;
      dest_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
`ifdef IMM_BUILDER_CHAIN_EN
      acc_q     <= acc_d;
      dest_q    <= dest_d;
`endif
    end
  end

  assign bus.RegWrite  = wr_en_q;
  assign bus.WriteReg  = wr_addr_q;
  assign bus.WriteData = wr_data_q;
  assign bus.err       = err_q;
  assign bus.in_ready  = (state_q != ST_WRITE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
